// File: rtl/cla_pkg.sv
// Shared definitions for the hierarchical carry-lookahead adder.
// The look-ahead carry unit and the sum stage reuse the beat layout below.
package cla_pkg;

    localparam int BLK_W = 4;
    localparam int NBLK  = 4;
    localparam int WIDTH = BLK_W * NBLK;

    // One buffered front-end result: bit-level P/G, block P/G and the carry-in.
    typedef struct packed {
        logic [WIDTH-1:0] p_bits;
        logic [WIDTH-1:0] g_bits;
        logic [NBLK-1:0]  blk_P;
        logic [NBLK-1:0]  blk_G;
        logic             c_in;
    } pg_beat_t;

    // Group generate of one block: g3 | p3g2 | p3p2g1 | p3p2p1g0.
    function automatic logic block_gen(input logic [BLK_W-1:0] p, input logic [BLK_W-1:0] g);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < BLK_W; i++) begin
            acc = g[i] | (p[i] & acc);
        end
        return acc;
    endfunction

endpackage

// File: rtl/cla_block_pg.sv
// Combinational 4-bit block propagate/generate generator.
module cla_block_pg
    import cla_pkg::*;
(
    input  logic [BLK_W-1:0] p,
    input  logic [BLK_W-1:0] g,
    output logic             blk_p,
    output logic             blk_g
);

    // Block propagates only if every bit propagates; generate ripples the chain.
    always_comb begin
        blk_p = &p;
        blk_g = block_gen(p, g);
    end

endmodule

// File: rtl/cla_pg_stage.sv
// Registered, handshaked P/G front-end of the hierarchical CLA.
// Bit and block P/G are computed combinationally from A/B and captured,
// together with c_in, into a 2-entry skid FIFO whose head drives the outputs.
// Optional transfer counter: define CLA_PG_XFER_CNT_EN to add xfer_cnt.
module cla_pg_stage
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLK_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] p_bits,
    output logic [WIDTH-1:0] g_bits,
    output logic [3:0]       blk_P,
    output logic [3:0]       blk_G,
    output logic             c_out_fwd
`ifdef CLA_PG_XFER_CNT_EN
    ,
    output logic [15:0]      xfer_cnt
`endif
);

    logic [WIDTH-1:0] p_s;
    logic [WIDTH-1:0] g_s;
    logic [3:0]       blk_p_s;
    logic [3:0]       blk_g_s;
    pg_beat_t         beat_s;
    pg_beat_t         head_beat_s;

    pg_beat_t         entry_r [2];
    logic             head_r;
    logic             tail_r;
    logic [1:0]       count_r;
    logic [1:0]       count_next_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             push_s;
    logic             pop_s;

    assign p_s = A ^ B;
    assign g_s = A & B;

    for (genvar k = 0; k < 4; k++) begin : g_blk
        cla_block_pg u_blk (
            .p     (p_s[k*BLK_W +: BLK_W]),
            .g     (g_s[k*BLK_W +: BLK_W]),
            .blk_p (blk_p_s[k]),
            .blk_g (blk_g_s[k])
        );
    end

    // Pack the freshly computed P/G and carry-in into one beat for the FIFO.
    always_comb begin
        beat_s.p_bits = p_s;
        beat_s.g_bits = g_s;
        beat_s.blk_P  = blk_p_s;
        beat_s.blk_G  = blk_g_s;
        beat_s.c_in   = c_in;
    end

    assign push_s = in_valid && in_ready_r;
    assign pop_s  = out_valid_r && out_ready;

    // Occupancy update: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage, pointers and registered handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_r[0]  <= '0;
            entry_r[1]  <= '0;
            head_r      <= 1'b0;
            tail_r      <= 1'b0;
            count_r     <= 2'd0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                entry_r[tail_r] <= beat_s;
                tail_r          <= ~tail_r;
            end
            if (pop_s) begin
                head_r <= ~head_r;
            end
            count_r     <= count_next_s;
            in_ready_r  <= (count_next_s != 2'd2);
            out_valid_r <= (count_next_s != 2'd0);
        end
    end

    assign head_beat_s = entry_r[head_r];

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign p_bits    = head_beat_s.p_bits;
    assign g_bits    = head_beat_s.g_bits;
    assign blk_P     = head_beat_s.blk_P;
    assign blk_G     = head_beat_s.blk_G;
    assign c_out_fwd = head_beat_s.c_in;

`ifdef CLA_PG_XFER_CNT_EN
    logic [15:0] xfer_cnt_r;

    // Count delivered beats, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_cnt_r <= 16'h0000;
        end else if (pop_s && (xfer_cnt_r != 16'hFFFF)) begin
            xfer_cnt_r <= xfer_cnt_r + 16'h0001;
        end
    end

    assign xfer_cnt = xfer_cnt_r;
`endif

endmodule

// File: tb/tb_cla_pg_stage.sv
// Self-checking bench for cla_pg_stage: directed steps plus random streaming,
// checked against a queue-based reference model.
module tb_cla_pg_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        c_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p_bits;
    logic [15:0] g_bits;
    logic [3:0]  blk_P;
    logic [3:0]  blk_G;
    logic        c_out_fwd;
`ifdef CLA_PG_XFER_CNT_EN
    logic [15:0] xfer_cnt;
`endif

    int tests = 0;
    int fails = 0;
    logic mon_en = 1'b0;
    logic [40:0] q [$];

    cla_pg_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p_bits    (p_bits),
        .g_bits    (g_bits),
        .blk_P     (blk_P),
        .blk_G     (blk_G),
        .c_out_fwd (c_out_fwd)
`ifdef CLA_PG_XFER_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference: block propagate = nibble of A^B all ones; block generate =
    // carry out of the nibble sum A+B with no carry in.
    function automatic logic [40:0] model(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [3:0] bp;
        logic [3:0] bg;
        logic [3:0] na;
        logic [3:0] nb;
        for (int k = 0; k < 4; k++) begin
            na = a[k*4 +: 4];
            nb = b[k*4 +: 4];
            bp[k] = ((na ^ nb) == 4'hF);
            bg[k] = ({1'b0, na} + {1'b0, nb}) > 5'd15;
        end
        return {a ^ b, a & b, bp, bg, c};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: occupancy, head data stability and FIFO order every cycle.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("mon_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
            check("mon_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
            if (out_valid && q.size() != 0) begin
                check("mon_data", {23'd0, p_bits, g_bits, blk_P, blk_G, c_out_fwd}, {23'd0, q[0]});
                if (out_ready) begin
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(A, B, c_in));
            end
        end
    end

    initial begin
        logic acc;
        rst = 1'b1; in_valid = 1'b0; A = 16'h0; B = 16'h0; c_in = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_p_bits", {48'd0, p_bits}, 64'd0);
        rst = 1'b0;
        tick();
        check("rel_in_ready", {63'd0, in_ready}, 64'd1);
        mon_en = 1'b1;

        // Directed beat 1
        A = 16'hFFFF; B = 16'h0001; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t1_valid", {63'd0, out_valid}, 64'd1);
        check("t1_p", {48'd0, p_bits}, 64'h0000_0000_0000_FFFE);
        check("t1_g", {48'd0, g_bits}, 64'h0000_0000_0000_0001);
        check("t1_bP", {60'd0, blk_P}, 64'b1110);
        check("t1_bG", {60'd0, blk_G}, 64'b0001);

        // Directed beat 2
        A = 16'h1234; B = 16'h0000; c_in = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t2_p", {48'd0, p_bits}, 64'h1234);
        check("t2_g", {48'd0, g_bits}, 64'd0);
        check("t2_bP", {60'd0, blk_P}, 64'd0);
        check("t2_bG", {60'd0, blk_G}, 64'd0);
        check("t2_cfwd", {63'd0, c_out_fwd}, 64'd1);
        tick();

        // Backpressure: two accepted, third held
        out_ready = 1'b0; B = 16'h0; c_in = 1'b0; in_valid = 1'b1;
        A = 16'h0001; tick();
        A = 16'h0002; tick();
        A = 16'h0003; tick(); tick();
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        check("bp_valid", {63'd0, out_valid}, 64'd1);
        check("bp_head", {48'd0, p_bits}, 64'h1);
        out_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            acc = in_ready;
            tick();
        end
        check("bp_accept_timeout", {63'd0, acc}, 64'd1);
        in_valid = 1'b0;
        repeat (4) tick();
        check("bp_drained", {63'd0, out_valid}, 64'd0);

        // Random streaming at one beat per cycle
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            A = 16'($urandom); B = 16'($urandom); c_in = 1'($urandom);
            tick();
            check("stream_ready", {63'd0, in_ready}, 64'd1);
            check("stream_valid", {63'd0, out_valid}, 64'd1);
        end
        in_valid = 1'b0;
        repeat (2) tick();
        check("stream_drained", {63'd0, out_valid}, 64'd0);

        // Reset mid-operation with the buffer full
        out_ready = 1'b0; in_valid = 1'b1;
        A = 16'hA5A5; B = 16'h5A5A; tick();
        A = 16'h0F0F; B = 16'hFFFF; tick();
        in_valid = 1'b0;
        #3;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_ready", {63'd0, in_ready}, 64'd0);
        check("mid_rst_p", {48'd0, p_bits}, 64'd0);
        q.delete();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_ready", {63'd0, in_ready}, 64'd1);
        check("post_rst_valid", {63'd0, out_valid}, 64'd0);
        mon_en = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        check("no_stale", {63'd0, out_valid}, 64'd0);

`ifdef CLA_PG_XFER_CNT_EN
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            A = 16'($urandom); B = 16'($urandom); tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        check("xfer_5", {48'd0, xfer_cnt}, 64'd5);
        in_valid = 1'b1;
        for (int i = 0; i < 65529; i++) begin
            A = 16'($urandom); B = 16'($urandom); tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        check("xfer_fffe", {48'd0, xfer_cnt}, 64'hFFFE);
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        repeat (2) tick();
        check("xfer_sat", {48'd0, xfer_cnt}, 64'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
